dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_load_align.sv | 38 +++
 rtl/dmem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access path: opcodes, FSM states, opcode helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dmem_pkg;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101010;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100010;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_DATA,
        RESP
    } state_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one; bytes never trap.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
        logic half_op;
        logic word_op;
        half_op = (op == OP_SH) || (op == OP_LH) || (op == OP_LHU);
        word_op = (op == OP_SW) || (op == OP_LW);
        return (half_op && lo[0]) || (word_op && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data lane extraction and sign/zero extension of a 32-bit SRAM word.
// Latency: combinational.
// Backpressure: none.
// Ports: rdata (raw SRAM word), addr (byte offset in word), opcode (load op), data (aligned result).
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [5:0]  opcode,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (opcode)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one load/store at a time against a synchronous SRAM.
// Latency: store done_o at T+1 (ready T+2); load rd_valid_o at T+3 (ready T+4); trap err_o at T+1.
// Backpressure: req_ready_o high only while idle; requests offered while busy are held off.
// Ports: req_valid_i/req_ready_o handshake with instr_opcode_i, addr_i, w_data_i, we_i;
//        mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o SRAM request, mem_rdata_i one cycle later;
//        rd_data_o/rd_valid_o load result, done_o store pulse, err_o misalignment pulse.
// Build option: DMEM_MISALIGN_TRAP_EN compiles in misaligned-access trapping.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [5:0]        instr_opcode_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       w_data_i,
    input  logic [3:0]        we_i,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       rd_data_o,
    output logic              rd_valid_o,
    output logic              done_o,
    output logic              err_o
);

    state_t            state_q, state_d;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        we_q;
    logic [31:0]       rd_data_q;
    logic [31:0]       load_data;
    logic              accept;
    logic              trap_hit;

`ifdef DMEM_MISALIGN_TRAP_EN
    // err_q marks the T+1 trap cycle; holding ready low there keeps the next accept at T+2.
    logic err_q;
    assign trap_hit    = is_misaligned(instr_opcode_i, addr_i[1:0]);
    assign req_ready_o = (state_q == IDLE) && !err_q;
    assign err_o       = err_q && !rst_i;
`else
    assign trap_hit    = 1'b0;
    assign req_ready_o = (state_q == IDLE);
    assign err_o       = 1'b0;
`endif

    assign accept    = req_valid_i && req_ready_o;
    assign rd_data_o = rd_data_q;

    dmem_load_align u_load_align (
        .rdata  (mem_rdata_i),
        .addr   (addr_q[1:0]),
        .opcode (op_q),
        .data   (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
            rd_data_q <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= instr_opcode_i;
                addr_q  <= addr_i;
                wdata_q <= w_data_i;
                we_q    <= we_i;
            end
            if (state_q == RD_DATA) begin
                rd_data_q <= load_data;
            end
`ifdef DMEM_MISALIGN_TRAP_EN
            err_q <= accept && trap_hit;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        done_o      = 1'b0;
        rd_valid_o  = 1'b0;

        case (state_q)
            IDLE: begin
                // Unknown opcodes are accepted and dropped without leaving IDLE.
                if (accept && !trap_hit) begin
                    if (is_store(instr_opcode_i)) begin
                        state_d = WRITE;
                    end else if (is_load(instr_opcode_i)) begin
                        state_d = RD_REQ;
                    end
                end
            end
            WRITE: begin
                mem_en_o    = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q[ADDR_W-1:2];
                mem_wdata_o = wdata_q;
                done_o      = 1'b1;
                state_d     = IDLE;
            end
            RD_REQ: begin
                mem_en_o   = 1'b1;
                mem_addr_o = addr_q[ADDR_W-1:2];
                state_d    = RD_DATA;
            end
            RD_DATA: begin
                state_d = RESP;
            end
            RESP: begin
                rd_valid_o = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset abandons the in-flight op: no SRAM write or completion pulse on the reset edge.
        if (rst_i) begin
            mem_en_o   = 1'b0;
            mem_we_o   = 4'b0000;
            done_o     = 1'b0;
            rd_valid_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: timeline reference model plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: offers requests while busy to confirm they are held off.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    localparam int NC = 2600;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [5:0]  instr_opcode_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] w_data_i = '0;
    logic [3:0]  we_i = '0;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        done_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    dmem_access_ctrl #(.ADDR_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .instr_opcode_i (instr_opcode_i),
        .addr_i         (addr_i),
        .w_data_i       (w_data_i),
        .we_i           (we_i),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    int cyc     = 0;
    int checks  = 0;
    int errors  = 0;
    int free_at = 0;
    bit chk_en  = 1'b0;

    // Expected behaviour per cycle index (interval following posedge number cyc).
    bit          e_ready[NC];
    bit          e_en[NC];
    logic [3:0]  e_we[NC];
    logic [31:0] e_addr[NC];
    logic [31:0] e_wdata[NC];
    bit          e_done[NC];
    bit          e_rv[NC];
    bit          e_err[NC];
    bit          rd_evt[NC];
    logic [31:0] rd_val[NC];
    bit          rs_vld[NC];
    logic [31:0] rs_dat[NC];
    logic [31:0] exp_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit f_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit f_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic bit f_trap(input logic [5:0] op, input logic [31:0] a);
        bit mis;
        mis = 1'b0;
        if (op inside {OP_SH, OP_LH, OP_LHU}) mis = (a % 2) != 0;
        if (op inside {OP_SW, OP_LW})         mis = (a % 4) != 0;
        return TRAP && mis;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a % 4))) & 32'hFF;
        h = (w >> (16 * int'((a / 2) % 2))) & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            OP_LHU:  return h;
            default: return w;
        endcase
    endfunction

    function automatic void clear_at(input int k);
        if (k < NC) begin
            e_ready[k] = 1'b1; e_en[k] = 1'b0; e_we[k] = '0; e_addr[k] = '0;
            e_wdata[k] = '0; e_done[k] = 1'b0; e_rv[k] = 1'b0; e_err[k] = 1'b0;
            rd_evt[k] = 1'b0; rd_val[k] = '0; rs_vld[k] = 1'b0; rs_dat[k] = '0;
        end
    endfunction

    function automatic void model_accept(input int c, input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] wd, input logic [3:0] we,
                                         input logic [31:0] rd);
        if (c + 4 >= NC) return;
        if (f_trap(op, a)) begin
            e_err[c+1] = 1'b1; e_ready[c+1] = 1'b0; free_at = c + 2;
        end else if (f_store(op)) begin
            e_en[c+1] = 1'b1; e_we[c+1] = we; e_addr[c+1] = a / 4; e_wdata[c+1] = wd;
            e_done[c+1] = 1'b1; e_ready[c+1] = 1'b0; free_at = c + 2;
        end else if (f_load(op)) begin
            e_en[c+1] = 1'b1; e_we[c+1] = 4'b0000; e_addr[c+1] = a / 4;
            rs_vld[c+2] = 1'b1; rs_dat[c+2] = rd;
            e_rv[c+3] = 1'b1; rd_evt[c+3] = 1'b1; rd_val[c+3] = ref_load(op, a, rd);
            for (int k = c + 1; k <= c + 3; k++) e_ready[k] = 1'b0;
            free_at = c + 4;
        end else begin
            free_at = c + 1;
        end
    endfunction

    function automatic void model_reset(input int r);
        if (r + 5 >= NC) return;
        e_en[r] = 1'b0; e_we[r] = '0; e_done[r] = 1'b0; e_rv[r] = 1'b0; e_err[r] = 1'b0;
        for (int k = r + 1; k <= r + 4; k++) clear_at(k);
        rd_evt[r+1] = 1'b1; rd_val[r+1] = '0;
        free_at = r + 1;
    endfunction

    // Per-cycle comparison against the timeline model.
    always @(negedge clk_i) begin
        if (chk_en && cyc < NC) begin
            if (rd_evt[cyc]) exp_rd = rd_val[cyc];
            chk("ready",    32'(req_ready_o), 32'(e_ready[cyc]));
            chk("mem_en",   32'(mem_en_o),    32'(e_en[cyc]));
            chk("mem_we",   32'(mem_we_o),    32'(e_we[cyc]));
            chk("done",     32'(done_o),      32'(e_done[cyc]));
            chk("rd_valid", 32'(rd_valid_o),  32'(e_rv[cyc]));
            chk("err",      32'(err_o),       32'(e_err[cyc]));
            chk("rd_data",  rd_data_o,        exp_rd);
            if (e_en[cyc]) begin
                chk("mem_addr", 32'(mem_addr_o), e_addr[cyc]);
                if (e_done[cyc]) chk("mem_wdata", mem_wdata_o, e_wdata[cyc]);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        cyc++;
        #1;
        rst_i          = 1'b0;
        req_valid_i    = 1'b0;
        instr_opcode_i = 6'($urandom);
        addr_i         = $urandom;
        w_data_i       = $urandom;
        we_i           = 4'($urandom);
        mem_rdata_i    = (cyc < NC && rs_vld[cyc]) ? rs_dat[cyc] : $urandom;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] we, input logic [31:0] rd);
        req_valid_i    = 1'b1;
        instr_opcode_i = op;
        addr_i         = a;
        w_data_i       = wd;
        we_i           = we;
        if (cyc >= free_at) model_accept(cyc, op, a, wd, we, rd);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] we, input logic [31:0] rd, output int t);
        int guard;
        guard = 0;
        while (cyc < free_at && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) begin
            checks++; errors++;
            $display("FAIL issue_timeout cyc=%0d got=busy want=idle", cyc);
        end
        drive(op, a, wd, we, rd);
        t = cyc;
        step();
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) step();
        #1;
    endtask

    function automatic logic [5:0] rnd_op();
        logic [5:0] tbl [8];
        int r;
        tbl = '{OP_SB, OP_SH, OP_SW, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        r = $urandom_range(0, 8);
        if (r == 8) return 6'($urandom);
        return tbl[r];
    endfunction

    initial begin
        int t;
        for (int k = 0; k < NC; k++) clear_at(k);

        for (int i = 0; i < 3; i++) begin
            step();
            rst_i = 1'b1;
        end
        model_reset(cyc);
        step();
        chk_en = 1'b1;
        #1;
        chk("rst_ready",    32'(req_ready_o), 32'd1);
        chk("rst_mem_en",   32'(mem_en_o),    32'd0);
        chk("rst_rd_valid", 32'(rd_valid_o),  32'd0);
        chk("rst_rd_data",  rd_data_o,        32'h0);
        chk("rst_done",     32'(done_o),      32'd0);

        // Word store.
        issue(OP_SW, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, t);
        wait_to(t + 1);
        chk("sw_en",    32'(mem_en_o),   32'd1);
        chk("sw_we",    32'(mem_we_o),   32'hF);
        chk("sw_addr",  32'(mem_addr_o), 32'h40);
        chk("sw_wdata", mem_wdata_o,     32'hDEADBEEF);
        chk("sw_done",  32'(done_o),     32'd1);
        wait_to(t + 2);
        chk("sw_ready", 32'(req_ready_o), 32'd1);

        // Store with no byte enables still completes.
        issue(OP_SB, 32'h200, 32'h55, 4'b0000, 32'h0, t);
        wait_to(t + 1);
        chk("sb0_en",   32'(mem_en_o), 32'd1);
        chk("sb0_done", 32'(done_o),   32'd1);

        // Byte loads, signed and unsigned.
        issue(OP_LB, 32'h103, 32'h0, 4'b0000, 32'h80FF0000, t);
        wait_to(t + 3);
        chk("lb_valid", 32'(rd_valid_o), 32'd1);
        chk("lb_data",  rd_data_o,       32'hFFFFFF80);
        issue(OP_LBU, 32'h103, 32'h0, 4'b0000, 32'h80FF0000, t);
        wait_to(t + 3);
        chk("lbu_data", rd_data_o, 32'h00000080);

        // Halfword loads, signed and unsigned.
        issue(OP_LH, 32'h102, 32'h0, 4'b0000, 32'h80011234, t);
        wait_to(t + 3);
        chk("lh_data", rd_data_o, 32'hFFFF8001);
        issue(OP_LHU, 32'h102, 32'h0, 4'b0000, 32'h80011234, t);
        wait_to(t + 3);
        chk("lhu_data", rd_data_o, 32'h00008001);
        wait_to(t + 5);
        chk("lhu_hold", rd_data_o, 32'h00008001);

        // Reset while the read request is on the SRAM port.
        issue(OP_LB, 32'h104, 32'h0, 4'b0000, 32'h000000AA, t);
        rst_i = 1'b1;
        model_reset(cyc);
        wait_to(t + 2);
        chk("rst_rdreq_ready", 32'(req_ready_o), 32'd1);
        wait_to(t + 3);
        chk("rst_rdreq_novalid", 32'(rd_valid_o), 32'd0);

        // Misaligned word load.
        issue(OP_LW, 32'h102, 32'h0, 4'b0000, 32'h12345678, t);
        wait_to(t + 1);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lwmis_err", 32'(err_o),    32'd1);
        chk("lwmis_en1", 32'(mem_en_o), 32'd0);
        wait_to(t + 2);
        chk("lwmis_en2",   32'(mem_en_o),    32'd0);
        chk("lwmis_ready", 32'(req_ready_o), 32'd1);
`else
        chk("lwmis_en",   32'(mem_en_o),   32'd1);
        chk("lwmis_we",   32'(mem_we_o),   32'd0);
        chk("lwmis_addr", 32'(mem_addr_o), 32'h40);
        wait_to(t + 3);
        chk("lwmis_valid", 32'(rd_valid_o), 32'd1);
        chk("lwmis_data",  rd_data_o,       32'h12345678);
`endif

        // Randomized traffic, including requests offered while busy and random resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst_i = 1'b1;
                model_reset(cyc);
            end else if ($urandom_range(0, 1) == 1) begin
                drive(rnd_op(), $urandom, $urandom, 4'($urandom), $urandom);
            end
            step();
        end

        for (int i = 0; i < 6; i++) step();
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
